// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF and MEM stages: one fixed-latency access at a time.
// Optional starvation guard for fetches enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("MEM_LAT must be within 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          own_if_q, own_if_d;
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          gnt_d, gnt_if;
  logic          force_if;

  assign gnt_d  = (state_q == S_IDLE) && d_req && !force_if;
  assign gnt_if = (state_q == S_IDLE) && if_req && !gnt_d;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] fair_q, fair_d;

  assign force_if = if_req && d_req && (fair_q == STARVE_LIM);

  // Counts consecutive data grants that left a fetch waiting.
  always_comb begin
    fair_d = fair_q;
    if (gnt_if) begin
      fair_d = '0;
    end else if (gnt_d) begin
      if (!if_req)
        fair_d = '0;
      else if (fair_q != STARVE_LIM)
        fair_d = fair_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) fair_q <= '0;
    else        fair_q <= fair_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_if_d    = own_if_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Memory strobe is registered here so it is high for exactly the ISSUE cycle.
        if (gnt_d || gnt_if) begin
          state_d     = S_ISSUE;
          own_if_d    = gnt_if;
          we_d        = gnt_d && d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = gnt_d && d_we;
          mem_addr_d  = gnt_d ? d_addr : if_addr;
          mem_wdata_d = (gnt_d && d_we) ? d_wdata : '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = LAT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          if_ack_d = own_if_q;
          d_ack_d  = !own_if_q;
          if (!we_q) begin
            if (own_if_q) if_rdata_d = mem_rdata;
            else          d_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      own_if_q    <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_if_q    <= own_if_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A at MEM_LAT=2, instance B at MEM_LAT=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        a_if_req, a_if_ack, a_d_req, a_d_we, a_d_ack;
  logic        a_stall_if, a_stall_mem, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack;
  logic        b_stall_if, b_stall_mem, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .stall_if(a_stall_if), .stall_mem(a_stall_mem),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory read data is only valid exactly MEM_LAT cycles after the strobe.
  logic        pa_v0 = 1'b0, pa_v1 = 1'b0, pb_v0 = 1'b0;
  logic [31:0] pa_a0 = '0, pa_a1 = '0, pb_a0 = '0;
  always @(posedge clk) begin
    pa_v0 <= a_mem_en & ~a_mem_we;
    pa_a0 <= a_mem_addr;
    pa_v1 <= pa_v0;
    pa_a1 <= pa_a0;
    pb_v0 <= b_mem_en & ~b_mem_we;
    pb_a0 <= b_mem_addr;
  end
  assign a_mem_rdata = pa_v1 ? mem_word(pa_a1) : 32'hBAD0BAD0;
  assign b_mem_rdata = pb_v0 ? mem_word(pb_a0) : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
    b_if_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge; the request is sampled at the following posedge (edge 0).
  task automatic a_access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
    if (is_d) begin
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_if_req = 1'b1; a_if_addr = addr;
    end
    #1;
    check("stall_c0", 32'(is_d ? a_stall_mem : a_stall_if), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("mem_en", 32'(a_mem_en), 32'(c == 1));
      if (c == 1) begin
        check("mem_addr", a_mem_addr, addr);
        check("mem_we", 32'(a_mem_we), 32'(we));
        check("mem_wdata", a_mem_wdata, we ? wdata : 32'h0);
      end
      check("ack", 32'(is_d ? a_d_ack : a_if_ack), 32'(c == 4));
      check("other_ack", 32'(is_d ? a_if_ack : a_d_ack), 32'd0);
      check("stall", 32'(is_d ? a_stall_mem : a_stall_if), 32'(c < 4));
      check("busy", 32'(a_busy), 32'(c <= 4));
      if (c == 4) begin
        check("done_mem_addr", a_mem_addr, 32'h0);
        check("done_mem_we", 32'(a_mem_we), 32'd0);
        check("rdata", is_d ? a_d_rdata : a_if_rdata, exp_rd);
        a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
      end
      if (c == 5) check("rdata_hold", is_d ? a_d_rdata : a_if_rdata, exp_rd);
    end
  endtask

  initial begin
    int n_dack, n_iack, n_seen, first, second, n_en;
    logic prev_en;
    logic [5:0] order;

    reset = 1'b0;
    a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    repeat (2) @(negedge clk);

    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_mem_en", 32'(a_mem_en), 32'd0);
    check("rst_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_if_ack", 32'(a_if_ack), 32'd0);
    check("rst_d_ack", 32'(a_d_ack), 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'h0);
    check("rst_mem_wdata", a_mem_wdata, 32'h0);
    check("rst_if_rdata", a_if_rdata, 32'h0);
    check("rst_d_rdata", a_d_rdata, 32'h0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    check("rst_b_mem_en", 32'(b_mem_en), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    a_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C010004);
    a_access(1'b1, 1'b0, 32'h200, 32'h0, 32'h0200FDFF);
    a_access(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0200FDFF);

    // Contention: D first, IF granted at the next IDLE sample.
    a_if_req = 1'b1; a_if_addr = 32'h80;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h300;
    #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("ct_mem_en", 32'(a_mem_en), 32'(c == 1 || c == 6));
      if (c == 1) check("ct_d_addr", a_mem_addr, 32'h300);
      if (c == 6) check("ct_if_addr", a_mem_addr, 32'h80);
      check("ct_d_ack", 32'(a_d_ack), 32'(c == 4));
      check("ct_if_ack", 32'(a_if_ack), 32'(c == 9));
      check("ct_stall_if", 32'(a_stall_if), 32'(c < 9));
      check("ct_stall_mem", 32'(a_stall_mem), 32'(c < 4));
      if (c == 4) begin
        check("ct_d_rdata", a_d_rdata, 32'h0300FCFF);
        a_d_req = 1'b0;
      end
      if (c == 9) begin
        check("ct_if_rdata", a_if_rdata, 32'h0080FF7F);
        a_if_req = 1'b0;
      end
    end

    // Sustained contention over 50 accesses.
    do_reset();
    a_if_req = 1'b1; a_if_addr = 32'h40;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h10;
    n_dack = 0; n_iack = 0; n_seen = 0; order = '0;
    for (int c = 1; c <= 250; c++) begin
      @(negedge clk);
      if (a_d_ack) begin
        n_dack++;
        n_seen++;
      end
      if (a_if_ack) begin
        n_iack++;
        if (n_seen < 6) order[n_seen] = 1'b1;
        n_seen++;
      end
      if (c == 250) begin
        a_if_req = 1'b0; a_d_req = 1'b0;
      end
    end
`ifdef ARB_FAIRNESS_EN
    check("fair_d_acks", 32'(n_dack), 32'd40);
    check("fair_if_acks", 32'(n_iack), 32'd10);
    check("fair_order", 32'(order), 32'b010000);
`else
    check("strict_d_acks", 32'(n_dack), 32'd50);
    check("strict_if_acks", 32'(n_iack), 32'd0);
`endif
    repeat (2) @(negedge clk);

    // Reset during WAIT discards the access.
    a_if_req = 1'b1; a_if_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; a_if_req = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(a_busy), 32'd0);
    check("mr_mem_en", 32'(a_mem_en), 32'd0);
    check("mr_mem_we", 32'(a_mem_we), 32'd0);
    check("mr_if_ack", 32'(a_if_ack), 32'd0);
    check("mr_d_ack", 32'(a_d_ack), 32'd0);
    check("mr_mem_addr", a_mem_addr, 32'h0);
    check("mr_mem_wdata", a_mem_wdata, 32'h0);
    check("mr_if_rdata", a_if_rdata, 32'h0);
    check("mr_d_rdata", a_d_rdata, 32'h0);
    reset = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      check("mr_no_ack", 32'(a_if_ack), 32'd0);
      check("mr_no_mem_en", 32'(a_mem_en), 32'd0);
    end
    a_access(1'b0, 1'b0, 32'h4, 32'h0, 32'h0004FFFB);

    // MEM_LAT=1: back-to-back fetches.
    b_if_req = 1'b1; b_if_addr = 32'h0;
    prev_en = 1'b0; first = -1; second = -1; n_en = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (b_mem_en) n_en++;
      check("b_no_b2b_en", 32'(prev_en & b_mem_en), 32'd0);
      prev_en = b_mem_en;
      if (b_if_ack) begin
        if (first < 0) begin
          first = c;
          check("b_rdata0", b_if_rdata, 32'h0000FFFF);
          b_if_addr = 32'h4;
        end else if (second < 0) begin
          second = c;
          check("b_rdata4", b_if_rdata, 32'h0004FFFB);
          b_if_req = 1'b0;
        end
      end
    end
    check("b_first_ack", 32'(first), 32'd3);
    check("b_ack_gap", 32'(second - first), 32'd4);
    check("b_mem_en_count", 32'(n_en), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
